dot_accum_seq: RTL and testbench

- Sequencer that sits directly upstream of adder_2in_2out in the TPU accumulate path.
- Accepts a stream of DATA_WIDTH partial products and drives the adder's in_a/in_b so it accumulates VEC_LEN terms.
- Feeds the adder's registered {hi_sum, low_sum} back as in_b.
- Captures the final 2*DATA_WIDTH dot-product result into an output slot with valid/ready handshake.

---
 rtl/dot_accum_seq.sv | 158 +++++++++++++++
 tb/tb_dot_accum_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accum_seq.sv
// ---------------------------------------------------------------------------
// dot_accum_seq
//
// Drives adder_2in_2out in the TPU accumulate path. A stream of DATA_WIDTH
// partial products arrives on term_data. The sequencer sends each term to the
// adder on add_a and feeds the registered adder sum {add_hi, add_low} back on
// add_b. After VEC_LEN terms it captures the dot product into a one-entry
// result slot that has a valid/ready handshake.
//
// Optional build macro:
//   DOT_ACCUM_BIAS_EN - adds bias_in. The first term of each vector is then
//                       added to bias_in instead of 0.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   term_data   unsigned partial product
//   term_valid  term_data valid
//   term_ready  sequencer accepts a term this cycle
//   add_a       to adder in_a (0 when no term is accepted)
//   add_b       to adder in_b (0/bias on first term, else the adder's sum)
//   add_low     from adder low_sum
//   add_hi      from adder hi_sum
//   res_data    captured dot product {add_hi, add_low}
//   res_valid   res_data valid
//   res_ready   consumer takes the result
//   bias_in     starting value of the sum (DOT_ACCUM_BIAS_EN only)
//   busy        a vector is in progress (state != IDLE)
// ---------------------------------------------------------------------------
module dot_accum_seq #(
  parameter int DATA_WIDTH = 18,
  parameter int VEC_LEN    = 16,
  parameter int CNT_W      = $clog2(VEC_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   term_data,
  input  logic                    term_valid,
  output logic                    term_ready,
  output logic [DATA_WIDTH-1:0]   add_a,
  output logic [2*DATA_WIDTH-1:0] add_b,
  input  logic [DATA_WIDTH-1:0]   add_low,
  input  logic [DATA_WIDTH-1:0]   add_hi,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
`ifdef DOT_ACCUM_BIAS_EN
  input  logic [2*DATA_WIDTH-1:0] bias_in,
`endif
  output logic                    busy
);

  localparam int ACC_W = 2 * DATA_WIDTH;

  // Count value held while the last term of a vector is being accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] first_b;
  logic             accept;
  logic             slot_free;
  logic             capture;

  assign acc = {add_hi, add_low};

`ifdef DOT_ACCUM_BIAS_EN
  assign first_b = bias_in;
`else
  assign first_b = '0;
`endif

  // The adder has no reset. Its sum is never trusted until a first term has
  // been sent with add_b = 0 (or the bias). During reset both operands are
  // forced to 0.
  always_comb begin
    // NOTE: every output of this block gets a default value first. A missing
    // branch then keeps the default instead of inferring a latch.
    term_ready = 1'b0;
    add_a      = '0;
    add_b      = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          term_ready = 1'b1;
          add_b      = term_valid ? first_b : '0;
        end
        ACCUM: begin
          term_ready = 1'b1;
          add_b      = acc;
        end
        // The final sum recirculates (add_a = 0) until the slot takes it.
        DRAIN, HOLD: add_b = acc;
        default: ;
      endcase
      // add_a stays at 0 on idle cycles, so the running sum holds.
      if (term_ready && term_valid) add_a = term_data;
    end
  end

  assign accept    = term_valid && term_ready;
  assign slot_free = !res_valid || res_ready;
  assign capture   = ((state == DRAIN) || (state == HOLD)) && slot_free;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: state elements are updated with non-blocking assignments only.
    // Every register then samples values from before this edge.
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      // Result slot. A capture in the same cycle as a pop replaces the entry
      // and keeps res_valid high.
      if (capture) begin
        res_data  <= acc;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CNT_W'(1);
            state <= (VEC_LEN == 1) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) state <= DRAIN;
          end
        end
        DRAIN, HOLD: begin
          if (slot_free) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_dot_accum_seq
//
// Two sequencers share clock and reset: u_dut4 (VEC_LEN=4) and u_dut1
// (VEC_LEN=1). Each one drives a behavioural 1-cycle adder model. This model
// has no reset and starts from a non-zero value.
//
// The stimulus process pushes each hand-computed dot product into a
// per-instance queue. A monitor pops the queue and compares on every cycle in
// which res_valid && res_ready. The stimulus process also checks the adder
// operands, term_ready, busy and the result slot at defined cycles.
//
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_dot_accum_seq;

  localparam int DW = 18;
  localparam int AW = 2 * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- VEC_LEN = 4 instance ----------------
  logic [DW-1:0] term_data4;
  logic          term_valid4;
  logic          term_ready4;
  logic [DW-1:0] add_a4;
  logic [AW-1:0] add_b4;
  logic [AW-1:0] acc4 = 36'hA5A5A5A5A;
  logic [AW-1:0] res_data4;
  logic          res_valid4;
  logic          res_ready4;
  logic          busy4;
  logic [AW-1:0] bias4 = '0;

  always @(posedge clk) acc4 <= {{DW{1'b0}}, add_a4} + add_b4;

  dot_accum_seq #(.DATA_WIDTH(DW), .VEC_LEN(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .term_data  (term_data4),
    .term_valid (term_valid4),
    .term_ready (term_ready4),
    .add_a      (add_a4),
    .add_b      (add_b4),
    .add_low    (acc4[DW-1:0]),
    .add_hi     (acc4[AW-1:DW]),
    .res_data   (res_data4),
    .res_valid  (res_valid4),
    .res_ready  (res_ready4),
`ifdef DOT_ACCUM_BIAS_EN
    .bias_in    (bias4),
`endif
    .busy       (busy4)
  );

  // ---------------- VEC_LEN = 1 instance ----------------
  logic [DW-1:0] term_data1;
  logic          term_valid1;
  logic          term_ready1;
  logic [DW-1:0] add_a1;
  logic [AW-1:0] add_b1;
  logic [AW-1:0] acc1 = 36'h5A5A5A5A5;
  logic [AW-1:0] res_data1;
  logic          res_valid1;
  logic          res_ready1;
  logic          busy1;

  always @(posedge clk) acc1 <= {{DW{1'b0}}, add_a1} + add_b1;

  dot_accum_seq #(.DATA_WIDTH(DW), .VEC_LEN(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .term_data  (term_data1),
    .term_valid (term_valid1),
    .term_ready (term_ready1),
    .add_a      (add_a1),
    .add_b      (add_b1),
    .add_low    (acc1[DW-1:0]),
    .add_hi     (acc1[AW-1:DW]),
    .res_data   (res_data1),
    .res_valid  (res_valid1),
    .res_ready  (res_ready1),
`ifdef DOT_ACCUM_BIAS_EN
    .bias_in    ('0),
`endif
    .busy       (busy1)
  );

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp4[$];
  logic [AW-1:0] exp1[$];

  task automatic check(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid4 && res_ready4) begin
      if (exp4.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL res4_unexpected: got 0x%0h expected no result", res_data4);
      end else begin
        check("res4_data", res_data4, exp4.pop_front());
      end
    end
    if (res_valid1 && res_ready1) begin
      if (exp1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL res1_unexpected: got 0x%0h expected no result", res_data1);
      end else begin
        check("res1_data", res_data1, exp1.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Feed up to four terms to u_dut4. Bit c of vpat is term_valid in cycle c.
  // The expected add_a/add_b of each cycle is checked. If do_push is set,
  // the hand-computed result goes to the scoreboard.
  task automatic feed4(input logic [DW-1:0] t0, input logic [DW-1:0] t1,
                       input logic [DW-1:0] t2, input logic [DW-1:0] t3,
                       input logic [15:0] vpat, input int plen,
                       input logic [AW-1:0] expv, input bit do_push);
    logic [DW-1:0] terms[4];
    logic [AW-1:0] run;
    logic [AW-1:0] first_b;
    logic [AW-1:0] exp_b;
    int k;
    terms = '{t0, t1, t2, t3};
`ifdef DOT_ACCUM_BIAS_EN
    first_b = bias4;
`else
    first_b = '0;
`endif
    run = first_b;
    k = 0;
    if (do_push) exp4.push_back(expv);
    for (int c = 0; c < plen; c++) begin
      term_valid4 = vpat[c] && (k < 4);
      term_data4  = term_valid4 ? terms[k] : 18'h3FFFF;
      exp_b = (k == 0) ? (term_valid4 ? first_b : '0) : run;
      @(negedge clk);
      check("feed_term_ready", term_ready4, 1);
      check("feed_add_a", add_a4, term_valid4 ? terms[k] : '0);
      check("feed_add_b", add_b4, exp_b);
      if (term_valid4) begin
        run = run + terms[k];
        k++;
      end
      next_cycle();
    end
    term_valid4 = 1'b0;
  endtask

  // Call in the cycle after the last accept (DRAIN). When the slot is free,
  // the result must be visible one cycle later.
  task automatic drain4(input logic [AW-1:0] expv, input bit free,
                        input logic rv_in_drain);
    @(negedge clk);
    check("drain_term_ready", term_ready4, 0);
    check("drain_busy", busy4, 1);
    check("drain_add_a", add_a4, 0);
    check("drain_add_b", add_b4, expv);
    check("drain_res_valid", res_valid4, rv_in_drain);
    next_cycle();
    if (free) begin
      @(negedge clk);
      check("capture_res_valid", res_valid4, 1);
      check("capture_res_data", res_data4, expv);
      check("capture_busy", busy4, 0);
      next_cycle();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n       = 1'b0;
    term_valid4 = 1'b1;
    term_data4  = 18'd5;
    res_ready4  = 1'b1;
    term_valid1 = 1'b0;
    term_data1  = '0;
    res_ready1  = 1'b1;

    // Reset: no term accepted and operands at 0, even with term_valid high.
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_term_ready", term_ready4, 0);
    check("rst_add_a", add_a4, 0);
    check("rst_add_b", add_b4, 0);
    check("rst_res_valid", res_valid4, 0);
    check("rst_res_data", res_data4, 0);
    check("rst_busy", busy4, 0);
    next_cycle();
    term_valid4 = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    check("idle_term_ready", term_ready4, 1);
    check("idle_busy", busy4, 0);
    next_cycle();

    // 1,2,3,4 back to back -> 10, valid two cycles after the 4th accept.
    feed4(18'd1, 18'd2, 18'd3, 18'd4, 16'h000F, 4, 36'd10, 1'b1);
    drain4(36'd10, 1'b1, 1'b0);

    // Same vector with valid pattern 1,0,1,0,0,1,1.
    feed4(18'd1, 18'd2, 18'd3, 18'd4, 16'b1100101, 7, 36'd10, 1'b1);
    drain4(36'd10, 1'b1, 1'b0);

    // Back-pressure: 10 waits in the slot, 26 waits in HOLD.
    res_ready4 = 1'b0;
    feed4(18'd1, 18'd2, 18'd3, 18'd4, 16'h000F, 4, 36'd10, 1'b1);
    drain4(36'd10, 1'b1, 1'b0);
    feed4(18'd5, 18'd6, 18'd7, 18'd8, 16'h000F, 4, 36'd26, 1'b1);
    check("bp_res_data_stable", res_data4, 36'd10);
    drain4(36'd26, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_term_ready", term_ready4, 0);
      check("hold_busy", busy4, 1);
      check("hold_add_b", add_b4, 36'd26);
      check("hold_res_valid", res_valid4, 1);
      check("hold_res_data", res_data4, 36'd10);
      next_cycle();
    end
    res_ready4 = 1'b1;
    @(negedge clk);
    check("release_res_data", res_data4, 36'd10);
    next_cycle();
    @(negedge clk);
    check("release2_res_data", res_data4, 36'd26);
    check("release2_busy", busy4, 0);
    next_cycle();

    // Maximum terms: 4 * 0x3FFFF = 0xFFFFC.
    feed4(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 16'h000F, 4,
          36'hFFFFC, 1'b1);
    drain4(36'hFFFFC, 1'b1, 1'b0);

`ifdef DOT_ACCUM_BIAS_EN
    // Bias 2^36-3 plus 1+1+1+1 wraps to 1.
    bias4 = 36'hFFFFFFFFD;
    feed4(18'd1, 18'd1, 18'd1, 18'd1, 16'h000F, 4, 36'd1, 1'b1);
    drain4(36'd1, 1'b1, 1'b0);
    bias4 = '0;
`endif

    // Reset in the middle of a vector discards the partial sum.
    feed4(18'd5, 18'd6, 18'd0, 18'd0, 16'h0003, 2, 36'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_term_ready", term_ready4, 0);
    check("midrst_add_b", add_b4, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_res_valid", res_valid4, 0);
    check("midrst_busy", busy4, 0);
    next_cycle();
    feed4(18'd1, 18'd1, 18'd1, 18'd1, 16'h000F, 4, 36'd4, 1'b1);
    drain4(36'd4, 1'b1, 1'b0);

    // VEC_LEN = 1: terms 7 and 9 streamed, one not-ready cycle after each.
    exp1.push_back(36'd7);
    exp1.push_back(36'd9);
    term_valid1 = 1'b1;
    term_data1  = 18'd7;
    @(negedge clk);
    check("v1_c0_term_ready", term_ready1, 1);
    check("v1_c0_add_a", add_a1, 36'd7);
    check("v1_c0_add_b", add_b1, 0);
    next_cycle();
    term_data1 = 18'd9;
    @(negedge clk);
    check("v1_c1_term_ready", term_ready1, 0);
    check("v1_c1_add_a", add_a1, 0);
    check("v1_c1_add_b", add_b1, 36'd7);
    check("v1_c1_busy", busy1, 1);
    next_cycle();
    @(negedge clk);
    check("v1_c2_term_ready", term_ready1, 1);
    check("v1_c2_add_a", add_a1, 36'd9);
    check("v1_c2_add_b", add_b1, 0);
    check("v1_c2_res_valid", res_valid1, 1);
    next_cycle();
    term_valid1 = 1'b0;
    @(negedge clk);
    check("v1_c3_term_ready", term_ready1, 0);
    check("v1_c3_add_b", add_b1, 36'd9);
    next_cycle();
    @(negedge clk);
    check("v1_c4_res_valid", res_valid1, 1);
    next_cycle();

    // Every pushed result must have been delivered exactly once.
    repeat (3) next_cycle();
    check("exp4_drained", 36'(exp4.size()), 0);
    check("exp1_drained", 36'(exp1.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
